hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3: source operands checked per issued instruction.
REQ-002 SHALL have parameter DEPTH, default 3: tracked in-flight stages (1=EX, 2=MEM, 3=WB).
REQ-003 SHALL have parameter MD_LAT, default 8: multi-cycle unit latency in cycles (range 2..255).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port issue_valid  in  1  instruction in ID requests issue.
REQ-007 SHALL have port issue_ready  out  1  issue accepted this cycle.
REQ-008 SHALL have port issue_we  in  1  instruction writes a register.
REQ-009 SHALL have port issue_rd  in  5  destination register.
REQ-010 SHALL have port issue_lat  in  2  result-ready stage (0=ALU result after EX, 1=load result after MEM).
REQ-011 SHALL have port issue_src  in  NUM_SRC*5  packed source registers.
REQ-012 SHALL have port issue_src_used  in  NUM_SRC  per-source valid mask.
REQ-013 SHALL have port issue_md  in  1  instruction targets the multi-cycle unit.
REQ-014 SHALL have port flush  in  1  squash the EX-stage entry and block issue this cycle.
REQ-015 SHALL have port fwd_sel  out  NUM_SRC*SELW  per-source select (0=register file, s=stage s, DEPTH+1=multi-cycle result); SELW=$clog2(DEPTH+2).
REQ-016 SHALL have ports md_busy  out  1, md_done  out  1  multi-cycle unit status.

Function
REQ-017 SHALL hold one entry {valid, rd, lat} per stage 1..DEPTH; each cycle stage s+1 <= stage s, and stage DEPTH retires.
REQ-018 SHALL load stage 1 with {issue_we, issue_rd, issue_lat} on an accepted non-md issue; otherwise with a bubble (valid=0).
REQ-019 SHALL treat an entry as matching source k iff valid && rd==src_k && rd!=0 && issue_src_used[k].
REQ-020 SHALL give priority to the smallest matching s (youngest producer).
REQ-021 SHALL set fwd_sel[k]=s when the youngest match has s > lat; SHALL set fwd_sel[k]=0 when no entry matches.
REQ-022 SHALL declare a hazard when the youngest match has s <= lat (load-use).
REQ-023 SHALL drive issue_ready = !(hazard || flush || md-stall); outputs are combinational from registered state plus issue inputs.
REQ-024 SHALL insert a bubble into stage 1 on a stall; in-flight entries advance regardless of stalls.
REQ-025 SHALL, on flush, clear the valid bit of the entry moving from stage 1 to stage 2 and load a bubble into stage 1.
REQ-026 SHALL, when issue_we=0, accept the issue with no match ever produced for it.

Reset
REQ-027 SHALL, while rst=1, clear all stage valid bits, md_busy, md_done, md counter and md_rd to 0 immediately; fwd_sel SHALL then read 0 and issue_ready SHALL read 1 unless flush=1.
REQ-028 SHALL discard any in-progress multi-cycle operation on reset mid-operation, with no md_done pulse.

Configuration
REQ-029 SHALL gate multi-cycle tracking with macro HAZ_MULDIV_EN.
REQ-030 SHALL, with HAZ_MULDIV_EN defined, accept an md issue only when !md_busy; on acceptance, set md_busy, md_rd=issue_rd, counter=MD_LAT-1, and insert no pipeline entry.
REQ-031 SHALL decrement the counter each cycle; at 0, pulse md_done for 1 cycle, give sources matching md_rd fwd_sel=DEPTH+1 that cycle, and clear md_busy on the next edge.
REQ-032 SHALL, while md_busy and md_done=0, stall any source matching md_rd and any new md issue (md-stall).
REQ-033 SHALL, without HAZ_MULDIV_EN, ignore issue_md (treated as a normal issue) and tie md_busy=0 and md_done=0.

Structure
REQ-034 SHALL place in shared package haz_pkg: the stage-entry typedef, FWD_RF=0, and SELW computation.
REQ-035 SHALL implement the multi-cycle counter as sub-module haz_md_tracker.

Verification
REQ-036 SHALL cover: add r3 issued; next-cycle source r3 -> fwd_sel=1, no stall.
REQ-037 SHALL cover: lw r5 (lat=1) issued; next-cycle source r5 -> 1 stall cycle, then fwd_sel=2.
REQ-038 SHALL cover: r4 written in stages 1 and 3; source r4 -> fwd_sel=1; rd=0 producer -> fwd_sel=0.
REQ-039 SHALL cover: flush with lw r7 in stage 1, dependent next cycle -> no stall, fwd_sel=0.
REQ-040 SHALL cover, with HAZ_MULDIV_EN and MD_LAT=8: md r9 issued; r9 consumer stalls 7 cycles; md_done in cycle 8 with fwd_sel=DEPTH+1; second md stalls until md_busy=0.
REQ-041 SHALL cover: rst asserted mid md operation -> md_busy=0 immediately, no md_done, all fwd_sel=0.

Source files
------------

// File: rtl/haz_pkg.sv
// haz_pkg: shared types and constants for the hazard_scoreboard slice
// (stage-entry record, register-file forwarding code, select width helper).
package haz_pkg;

    localparam int REG_W    = 5;
    localparam int LAT_W    = 2;
    localparam int MD_CNT_W = 8;
    localparam int FWD_RF   = 0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic [LAT_W-1:0] lat;
    } stage_t;

    // Select codes run 0 (register file) .. DEPTH+1 (multi-cycle result).
    function automatic int sel_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/haz_md_tracker.sv
// haz_md_tracker: latency countdown for the single outstanding multi-cycle
// (mul/div) operation; done is a one-cycle pulse while the counter sits at 0.
module haz_md_tracker
    import haz_pkg::*;
#(
    parameter int MD_LAT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [REG_W-1:0] i_rd,
    output logic             o_busy,
    output logic             o_done,
    output logic [REG_W-1:0] o_rd
);

    logic                r_busy;
    logic [MD_CNT_W-1:0] r_cnt;
    logic [REG_W-1:0]    r_rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rd   <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= MD_CNT_W'(MD_LAT - 1);
            r_rd   <= i_rd;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - MD_CNT_W'(1);
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == '0);
    assign o_rd   = r_rd;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination tracking, forwarding selects and
// load-use stall for the ID stage. Multi-cycle unit tracking built only with HAZ_MULDIV_EN.
module hazard_scoreboard
    import haz_pkg::*;
#(
    parameter  int NUM_SRC = 3,
    parameter  int DEPTH   = 3,
    parameter  int MD_LAT  = 8,
    localparam int SELW    = sel_width(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic                      issue_we,
    input  logic [REG_W-1:0]          issue_rd,
    input  logic [LAT_W-1:0]          issue_lat,
    input  logic [NUM_SRC*REG_W-1:0]  issue_src,
    input  logic [NUM_SRC-1:0]        issue_src_used,
    input  logic                      issue_md,
    input  logic                      flush,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      md_busy,
    output logic                      md_done
);

    stage_t             r_stage [1:DEPTH];
    logic               w_md_busy;
    logic               w_md_done;
    logic [REG_W-1:0]   w_md_rd;
    logic               w_md_issue_stall;
    logic               w_accept;
    logic               w_load;
    logic [NUM_SRC-1:0] w_src_haz;
    logic [NUM_SRC-1:0] w_src_md_stall;

`ifdef HAZ_MULDIV_EN
    logic w_md_start;

    assign w_md_start       = w_accept && issue_md;
    assign w_load           = w_accept && !issue_md;
    // A new md op waits for the unit to drain completely, including its done cycle.
    assign w_md_issue_stall = issue_md && w_md_busy;

    haz_md_tracker #(
        .MD_LAT (MD_LAT)
    ) u_md_tracker (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_md_start),
        .i_rd    (issue_rd),
        .o_busy  (w_md_busy),
        .o_done  (w_md_done),
        .o_rd    (w_md_rd)
    );
`else
    logic                w_unused_md;
    logic [MD_CNT_W-1:0] w_unused_lat;

    assign w_unused_md      = issue_md;
    assign w_unused_lat     = MD_CNT_W'(MD_LAT);
    assign w_load           = w_accept;
    assign w_md_issue_stall = 1'b0;
    assign w_md_busy        = 1'b0;
    assign w_md_done        = 1'b0;
    assign w_md_rd          = '0;
`endif

    // Youngest-producer search per source; a hazarded source keeps select 0.
    always_comb begin
        logic [REG_W-1:0] w_src;
        logic [SELW-1:0]  w_hit;
        logic [LAT_W-1:0] w_hit_lat;
        w_src          = '0;
        w_hit          = '0;
        w_hit_lat      = '0;
        fwd_sel        = {NUM_SRC{SELW'(FWD_RF)}};
        w_src_haz      = '0;
        w_src_md_stall = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_src     = issue_src[k*REG_W +: REG_W];
            w_hit     = '0;
            w_hit_lat = '0;
            for (int s = DEPTH; s >= 1; s--) begin
                if (r_stage[s].valid && (r_stage[s].rd == w_src) &&
                    (w_src != '0) && issue_src_used[k]) begin
                    w_hit     = SELW'(s);
                    w_hit_lat = r_stage[s].lat;
                end
            end
            if (w_hit != '0) begin
                if (int'(w_hit) > int'(w_hit_lat)) begin
                    fwd_sel[k*SELW +: SELW] = w_hit;
                end else begin
                    w_src_haz[k] = 1'b1;
                end
            end else if (w_md_busy && (w_md_rd == w_src) &&
                         (w_src != '0) && issue_src_used[k]) begin
                if (w_md_done) begin
                    fwd_sel[k*SELW +: SELW] = SELW'(DEPTH + 1);
                end else begin
                    w_src_md_stall[k] = 1'b1;
                end
            end
        end
    end

    assign issue_ready = !((|w_src_haz) || (|w_src_md_stall) || w_md_issue_stall || flush);
    assign w_accept    = issue_valid && issue_ready;
    assign md_busy     = w_md_busy;
    assign md_done     = w_md_done;

    // Stage shift: in-flight entries always advance; stalls and flushes feed bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 1; s <= DEPTH; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            if (w_load) begin
                r_stage[1].valid <= issue_we;
                r_stage[1].rd    <= issue_rd;
                r_stage[1].lat   <= issue_lat;
            end else begin
                r_stage[1] <= '0;
            end
            for (int s = 2; s <= DEPTH; s++) begin
                r_stage[s] <= r_stage[s-1];
                if (s == 2 && flush) begin
                    r_stage[s].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios plus a randomized run checked
// against an issue-timeline reference model of the scoreboard.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    localparam int NUM_SRC = 3;
    localparam int DEPTH   = 3;
    localparam int MD_LAT  = 8;
    localparam int SELW    = $clog2(DEPTH + 2);
    localparam int RND_N   = 400;

    logic                    clk;
    logic                    rst;
    logic                    issue_valid;
    logic                    issue_ready;
    logic                    issue_we;
    logic [4:0]              issue_rd;
    logic [1:0]              issue_lat;
    logic [NUM_SRC*5-1:0]    issue_src;
    logic [NUM_SRC-1:0]      issue_src_used;
    logic                    issue_md;
    logic                    flush;
    logic [NUM_SRC*SELW-1:0] fwd_sel;
    logic                    md_busy;
    logic                    md_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what was accepted in each cycle of the random run.
    logic       m_acc [0:RND_N-1];
    logic       m_we  [0:RND_N-1];
    logic [4:0] m_rd  [0:RND_N-1];
    logic [1:0] m_lat [0:RND_N-1];
    logic       m_sq  [0:RND_N-1];

    hazard_scoreboard #(
        .NUM_SRC (NUM_SRC),
        .DEPTH   (DEPTH),
        .MD_LAT  (MD_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_we       (issue_we),
        .issue_rd       (issue_rd),
        .issue_lat      (issue_lat),
        .issue_src      (issue_src),
        .issue_src_used (issue_src_used),
        .issue_md       (issue_md),
        .flush          (flush),
        .fwd_sel        (fwd_sel),
        .md_busy        (md_busy),
        .md_done        (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] lat, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] used, input logic md,
                         input logic fl);
        issue_valid    = v;
        issue_we       = we;
        issue_rd       = rd;
        issue_lat      = lat;
        issue_src      = {s2, s1, s0};
        issue_src_used = used;
        issue_md       = md;
        flush          = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < DEPTH + 1; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 5'd3, 2'd0, 5'd1, 5'd2, 5'd3, 3'b111, 1'b0, 1'b0);
        #2;
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", issue_ready); end
        n_tests++; if (fwd_sel !== '0) begin n_fail++; $display("FAIL reset_fwd: got %h expected 0", fwd_sel); end
        n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy: got %b expected 0", md_busy); end
        n_tests++; if (md_done !== 1'b0) begin n_fail++; $display("FAIL reset_md_done: got %b expected 0", md_done); end
        flush = 1'b1;
        #1;
        n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL reset_flush_ready: got %b expected 0", issue_ready); end
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_alu_fwd();
        drain();
        drive(1'b1, 1'b1, 5'd3, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL alu_issue_ready: got %b expected 1", issue_ready); end
        tick();
        drive(1'b1, 1'b1, 5'd6, 2'd0, 5'd3, 5'd3, 5'd2, 3'b011, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL alu_dep_ready: got %b expected 1", issue_ready); end
        n_tests++; if (fwd_sel !== 9'({3'd0, 3'd1, 3'd1})) begin n_fail++; $display("FAIL alu_dep_fwd: got %h expected %h", fwd_sel, 9'({3'd0, 3'd1, 3'd1})); end
        tick();
    endtask

    task automatic test_load_use();
        drain();
        drive(1'b1, 1'b1, 5'd5, 2'd1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd6, 2'd0, 5'd5, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_stall: got %b expected 0", issue_ready); end
        tick();
        @(negedge clk);
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL load_use_release: got %b expected 1", issue_ready); end
        n_tests++; if (fwd_sel[SELW-1:0] !== 3'd2) begin n_fail++; $display("FAIL load_use_fwd: got %0d expected 2", fwd_sel[SELW-1:0]); end
        tick();
    endtask

    task automatic test_priority_rd0();
        drain();
        drive(1'b1, 1'b1, 5'd4, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd8, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd4, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd0, 2'd0, 5'd4, 5'd8, 5'd0, 3'b011, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (fwd_sel !== 9'({3'd0, 3'd2, 3'd1})) begin n_fail++; $display("FAIL prio_youngest: got %h expected %h", fwd_sel, 9'({3'd0, 3'd2, 3'd1})); end
        tick();
        drive(1'b1, 1'b0, 5'd0, 2'd0, 5'd0, 5'd4, 5'd8, 3'b111, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready: got %b expected 1", issue_ready); end
        n_tests++; if (fwd_sel !== 9'({3'd3, 3'd2, 3'd0})) begin n_fail++; $display("FAIL rd0_fwd: got %h expected %h", fwd_sel, 9'({3'd3, 3'd2, 3'd0})); end
        tick();
    endtask

    task automatic test_flush();
        drain();
        drive(1'b1, 1'b1, 5'd7, 2'd1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd9, 2'd0, 5'd7, 5'd0, 5'd0, 3'b001, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_block: got %b expected 0", issue_ready); end
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL flush_no_stall: got %b expected 1", issue_ready); end
        n_tests++; if (fwd_sel !== '0) begin n_fail++; $display("FAIL flush_fwd: got %h expected 0", fwd_sel); end
        tick();
    endtask

    task automatic test_we0();
        drain();
        drive(1'b1, 1'b0, 5'd9, 2'd1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd2, 2'd0, 5'd9, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL we0_ready: got %b expected 1", issue_ready); end
        n_tests++; if (fwd_sel !== '0) begin n_fail++; $display("FAIL we0_fwd: got %h expected 0", fwd_sel); end
        tick();
    endtask

`ifdef HAZ_MULDIV_EN
    task automatic test_md();
        drain();
        drive(1'b1, 1'b1, 5'd9, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL md_issue_ready: got %b expected 1", issue_ready); end
        tick();
        drive(1'b1, 1'b1, 5'd20, 2'd0, 5'd9, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        for (int i = 1; i < MD_LAT; i++) begin
            @(negedge clk);
            n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL md_consumer_stall c%0d: got %b expected 0", i, issue_ready); end
            n_tests++; if (md_busy !== 1'b1 || md_done !== 1'b0) begin n_fail++; $display("FAIL md_status c%0d: got busy=%b done=%b expected busy=1 done=0", i, md_busy, md_done); end
            tick();
        end
        @(negedge clk);
        n_tests++; if (md_done !== 1'b1) begin n_fail++; $display("FAIL md_done_pulse: got %b expected 1", md_done); end
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL md_done_ready: got %b expected 1", issue_ready); end
        n_tests++; if (fwd_sel[SELW-1:0] !== 3'(DEPTH + 1)) begin n_fail++; $display("FAIL md_done_fwd: got %0d expected %0d", fwd_sel[SELW-1:0], DEPTH + 1); end
        tick();
        drive(1'b1, 1'b1, 5'd21, 2'd0, 5'd9, 5'd0, 5'd0, 3'b001, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin n_fail++; $display("FAIL md_cleared: got busy=%b done=%b expected 0 0", md_busy, md_done); end
        n_tests++; if (fwd_sel[SELW-1:0] !== 3'd0) begin n_fail++; $display("FAIL md_after_fwd: got %0d expected 0", fwd_sel[SELW-1:0]); end
        tick();
        drain();
        drive(1'b1, 1'b1, 5'd10, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd11, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0);
        for (int i = 1; i <= MD_LAT; i++) begin
            @(negedge clk);
            n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL md_second_stall c%0d: got %b expected 0", i, issue_ready); end
            tick();
        end
        @(negedge clk);
        n_tests++; if (issue_ready !== 1'b1 || md_busy !== 1'b0) begin n_fail++; $display("FAIL md_second_accept: got ready=%b busy=%b expected 1 0", issue_ready, md_busy); end
        tick();
        idle();
    endtask

    task automatic test_md_reset();
        drain();
        for (int i = 0; i < MD_LAT + 2; i++) tick();
        drive(1'b1, 1'b1, 5'd12, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 5'd22, 2'd0, 5'd12, 5'd12, 5'd12, 3'b111, 1'b0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL mdrst_pre_stall: got %b expected 0", issue_ready); end
        #1;
        rst = 1'b1;
        #1;
        n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL mdrst_busy: got %b expected 0", md_busy); end
        n_tests++; if (fwd_sel !== '0) begin n_fail++; $display("FAIL mdrst_fwd: got %h expected 0", fwd_sel); end
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL mdrst_ready: got %b expected 1", issue_ready); end
        tick();
        rst = 1'b0;
        issue_valid = 1'b0;
        for (int i = 0; i < MD_LAT + 2; i++) begin
            @(negedge clk);
            n_tests++; if (md_done !== 1'b0 || fwd_sel !== '0) begin n_fail++; $display("FAIL mdrst_after c%0d: got done=%b fwd=%h expected 0 0", i, md_done, fwd_sel); end
            tick();
        end
    endtask
`else
    task automatic test_md_ignored();
        drain();
        drive(1'b1, 1'b1, 5'd13, 2'd0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL mdoff_ready: got %b expected 1", issue_ready); end
        tick();
        drive(1'b1, 1'b1, 5'd14, 2'd0, 5'd13, 5'd0, 5'd0, 3'b001, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if (fwd_sel[SELW-1:0] !== 3'd1) begin n_fail++; $display("FAIL mdoff_fwd: got %0d expected 1", fwd_sel[SELW-1:0]); end
        n_tests++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin n_fail++; $display("FAIL mdoff_status: got busy=%b done=%b expected 0 0", md_busy, md_done); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic       v, we, md, fl, haz, found;
        logic [4:0] rd;
        logic [1:0] lat;
        logic [4:0] src [3];
        logic [2:0] used;
        int         exp_sel [3];
        logic       exp_hz  [3];
        logic       exp_rdy;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        for (int c = 0; c < RND_N; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            we   = ($urandom_range(0, 3) != 0);
            rd   = 5'($urandom_range(0, 7));
            lat  = 2'($urandom_range(0, 2));
            used = 3'($urandom);
            fl   = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < 3; k++) src[k] = 5'($urandom_range(0, 7));
`ifdef HAZ_MULDIV_EN
            md = 1'b0;
`else
            md = 1'($urandom_range(0, 1));
`endif
            // An instruction accepted in cycle p sits in stage c-p during cycle c.
            haz = 1'b0;
            for (int k = 0; k < 3; k++) begin
                exp_sel[k] = 0;
                exp_hz[k]  = 1'b0;
                found      = 1'b0;
                if (used[k] && src[k] != 5'd0) begin
                    for (int s = 1; s <= DEPTH; s++) begin
                        if (!found && (c - s) >= 0) begin
                            if (m_acc[c-s] && m_we[c-s] && !m_sq[c-s] && m_rd[c-s] == src[k]) begin
                                found = 1'b1;
                                if (s > int'(m_lat[c-s])) exp_sel[k] = s;
                                else exp_hz[k] = 1'b1;
                            end
                        end
                    end
                end
                haz = haz | exp_hz[k];
            end
            exp_rdy = !(haz || fl);
            drive(v, we, rd, lat, src[0], src[1], src[2], used, md, fl);
            @(negedge clk);
            n_tests++; if (issue_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, issue_ready, exp_rdy); end
            for (int k = 0; k < 3; k++) begin
                if (!exp_hz[k]) begin
                    n_tests++;
                    if (fwd_sel[k*SELW +: SELW] !== 3'(exp_sel[k])) begin
                        n_fail++;
                        $display("FAIL rnd_fwd c%0d src%0d: got %0d expected %0d", c, k, fwd_sel[k*SELW +: SELW], exp_sel[k]);
                    end
                end
            end
            m_acc[c] = v && exp_rdy;
            m_we[c]  = we;
            m_rd[c]  = rd;
            m_lat[c] = lat;
            m_sq[c]  = 1'b0;
            if (fl && c >= 1) m_sq[c-1] = 1'b1;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_priority_rd0();
        test_flush();
        test_we0();
`ifdef HAZ_MULDIV_EN
        test_md();
        test_md_reset();
`else
        test_md_ignored();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
